// File: rtl/seg7_pkg.sv
// Shared segment patterns (bit 0 = a ... bit 6 = g, logical active-high)
// and the parameter legality check for the scan driver.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic params_legal(int num_digits, int scan_div);
      return (num_digits >= 1) && (num_digits <= 8) && (scan_div >= 2);
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-segment encoder; BCD mode blanks nibbles above 9.
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       mode_hex,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (mode_hex || (nibble <= 4'd9))) begin
         case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with shadow/active data
// registers swapped only at frame boundaries so no frame mixes old and new data.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int COMMON_ANODE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    mode_hex,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    update_pending,
   output logic                    frame_done
);

   localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int              PW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic            POL      = (COMMON_ANODE != 0);
   localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]   PTR_LAST = PW'(NUM_DIGITS - 1);

   if (!params_legal(NUM_DIGITS, SCAN_DIV)) begin : g_param_check
      $error("seg7_scan_driver: NUM_DIGITS must be 1..8 and SCAN_DIV >= 2");
   end

   logic [CW-1:0]           cnt;
   logic [PW-1:0]           ptr;
   logic [4*NUM_DIGITS-1:0] sh_value, act_value;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
   logic                    sh_hex, act_hex;
   logic                    sh_lz, act_lz;

   logic                    tick, boundary;
   logic                    zero_above;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_nibble;
   logic                    cur_dp, cur_blank;
   logic [NUM_DIGITS-1:0]   cur_en;
   logic [6:0]              enc_seg;

   assign tick     = (cnt == CNT_LAST);
   assign boundary = tick && (ptr == PTR_LAST);

   always_comb begin
      zero_above = 1'b1;
      lz_mask    = '0;
      // Walk from the most significant digit down; digit 0 is never blanked.
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
         lz_mask[i] = act_lz && zero_above;
      end

      cur_nibble = '0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_en     = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (ptr == PW'(i)) begin
            cur_nibble = act_value[4*i +: 4];
            cur_dp     = act_dp[i];
            cur_blank  = lz_mask[i];
            cur_en[i]  = 1'b1;
         end
      end
   end

   seg7_encode u_encode (
      .nibble   (cur_nibble),
      .mode_hex (act_hex),
      .blank    (cur_blank),
      .seg      (enc_seg)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt            <= '0;
         ptr            <= '0;
         sh_value       <= '0;
         sh_dp          <= '0;
         sh_hex         <= 1'b0;
         sh_lz          <= 1'b0;
         act_value      <= '0;
         act_dp         <= '0;
         act_hex        <= 1'b0;
         act_lz         <= 1'b0;
         update_pending <= 1'b0;
         frame_done     <= 1'b0;
         seg            <= {7{POL}};
         dp             <= POL;
         digit_en       <= {NUM_DIGITS{POL}};
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         frame_done <= boundary;

         if (tick) begin
            ptr      <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            seg      <= enc_seg ^ {7{POL}};
            dp       <= cur_dp ^ POL;
            digit_en <= cur_en ^ {NUM_DIGITS{POL}};
         end

         if (load) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_hex   <= mode_hex;
            sh_lz    <= blank_lz;
         end

         // A load landing on the boundary tick bypasses the shadow stage.
         if (load && boundary) begin
            act_value      <= value;
            act_dp         <= dp_in;
            act_hex        <= mode_hex;
            act_lz         <= blank_lz;
            update_pending <= 1'b0;
         end else if (load) begin
            update_pending <= 1'b1;
         end else if (boundary && update_pending) begin
            act_value      <= sh_value;
            act_dp         <= sh_dp;
            act_hex        <= sh_hex;
            act_lz         <= sh_lz;
            update_pending <= 1'b0;
         end
      end
   end

endmodule
